pipeline_stage: RTL and testbench

PIPELINE_STAGE -- requirements
Module: pipeline_stage

---
 rtl/pipeline_stage.sv | 140 ++++++++++++++
 tb/tb_pipeline_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage.sv
// Valid/ready pipeline register with an optional two-entry skid buffer and a
// halt/freeze control that stalls all entry state while keeping the halt flag live.
module pipeline_stage #(
  parameter int DATA_W   = 16,
  parameter int NUM_DATA = 5,
  parameter int FLAG_W   = 16,
  parameter int SKID     = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       exec,
  input  logic                       halt_cmd,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [FLAG_W-1:0]          in_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [FLAG_W-1:0]          out_flags,
  output logic                       halted,
  output logic [1:0]                 occupancy
);

  localparam int  WORDS_W  = NUM_DATA * DATA_W;
  localparam bit  HAS_SKID = (SKID != 0);

  logic               halted_q,  halted_d;
  logic               m_valid_q, m_valid_d;
  logic [WORDS_W-1:0] m_data_q,  m_data_d;
  logic [FLAG_W-1:0]  m_flags_q, m_flags_d;
  logic               s_valid_q, s_valid_d;
  logic [WORDS_W-1:0] s_data_q,  s_data_d;
  logic [FLAG_W-1:0]  s_flags_q, s_flags_d;

  logic freeze;
  logic accept;
  logic pop;

  // An exec pulse while halted unfreezes the stage in that same cycle.
  always_comb begin
    freeze    = (halted_q ^ exec) | halt_cmd | ~enable;
    out_valid = m_valid_q & ~freeze & ~flush;
    if (HAS_SKID) begin
      in_ready = ~s_valid_q & ~freeze & ~flush;
    end else begin
      in_ready = (~m_valid_q | out_ready) & ~freeze & ~flush;
    end
    accept = in_valid & in_ready;
    pop    = out_valid & out_ready;
  end

  always_comb begin
    if (exec) begin
      halted_d = ~halted_q;
    end else if (halt_cmd) begin
      halted_d = 1'b1;
    end else begin
      halted_d = halted_q;
    end
  end

  // Empty entries always carry zero data, so out_data needs no output mask.
  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no branch leaves it unassigned (no latches).
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_flags_d = m_flags_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_flags_d = s_flags_q;

    if (!freeze) begin
      if (flush) begin
        m_valid_d = 1'b0;
        m_data_d  = '0;
        m_flags_d = '0;
        s_valid_d = 1'b0;
        s_data_d  = '0;
        s_flags_d = '0;
      end else if (!m_valid_q) begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
          m_flags_d = in_flags;
        end
      end else if (!s_valid_q) begin
        if (pop && accept) begin
          m_data_d  = in_data;
          m_flags_d = in_flags;
        end else if (pop) begin
          m_valid_d = 1'b0;
          m_data_d  = '0;
          m_flags_d = '0;
        end else if (accept && HAS_SKID) begin
          s_valid_d = 1'b1;
          s_data_d  = in_data;
          s_flags_d = in_flags;
        end
      end else if (pop) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_flags_d = s_flags_q;
        s_valid_d = 1'b0;
        s_data_d  = '0;
        s_flags_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: data registers are reset too, because empty entries must read back as zero.
    if (reset) begin
      halted_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_flags_q <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_flags_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      halted_q  <= halted_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_flags_q <= m_flags_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_flags_q <= s_flags_d;
    end
  end

  assign out_data  = m_data_q;
  assign out_flags = m_flags_q;
  assign halted    = halted_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_pipeline_stage.sv
// Directed bench for pipeline_stage: one skid instance and one single-entry
// instance driven from the same stimulus, each checked against hand-derived values.
module tb_pipeline_stage;

  localparam logic [31:0] A_D = 32'h0002_0001;
  localparam logic [31:0] B_D = 32'h0004_0003;
  localparam logic [31:0] C_D = 32'h0006_0005;
  localparam logic [3:0]  A_F = 4'h5;
  localparam logic [3:0]  B_F = 4'hA;
  localparam logic [3:0]  C_F = 4'h3;

  logic        clock = 1'b0;
  logic        reset, exec, halt_cmd, enable, flush;
  logic        in_valid, out_ready;
  logic [31:0] in_data;
  logic [3:0]  in_flags;

  logic        in_ready, out_valid, halted;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [1:0]  occupancy;

  logic        in_ready0, out_valid0, halted0;
  logic [31:0] out_data0;
  logic [3:0]  out_flags0;
  logic [1:0]  occupancy0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipeline_stage #(.DATA_W(16), .NUM_DATA(2), .FLAG_W(4), .SKID(1)) dut (
    .clock(clock), .reset(reset), .exec(exec), .halt_cmd(halt_cmd),
    .enable(enable), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_flags(in_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .halted(halted), .occupancy(occupancy)
  );

  pipeline_stage #(.DATA_W(16), .NUM_DATA(2), .FLAG_W(4), .SKID(0)) dut0 (
    .clock(clock), .reset(reset), .exec(exec), .halt_cmd(halt_cmd),
    .enable(enable), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_flags(in_flags), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_flags(out_flags0),
    .halted(halted0), .occupancy(occupancy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] f);
    in_valid = 1'b1;
    in_data  = d;
    in_flags = f;
    tick();
  endtask

  initial begin
    reset = 1'b1; exec = 1'b0; halt_cmd = 1'b0; enable = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_flags = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_halted",    32'(halted),    32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);

    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming at full rate
    out_ready = 1'b1;
    push(A_D, A_F);
    check("stream_a_valid", 32'(out_valid), 32'd1);
    check("stream_a_data",  out_data,       A_D);
    check("stream_a_flags", 32'(out_flags), 32'(A_F));
    check("stream_a_occ",   32'(occupancy), 32'd1);
    push(B_D, B_F);
    check("stream_b_data",  out_data,       B_D);
    check("stream_b_flags", 32'(out_flags), 32'(B_F));
    check("stream_b_occ",   32'(occupancy), 32'd1);
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 32'(out_valid), 32'd0);
    check("stream_end_occ",   32'(occupancy), 32'd0);
    check("stream_end_data",  out_data,       32'd0);

    // Backpressure fills the skid entry
    out_ready = 1'b0;
    push(A_D, A_F);
    push(B_D, B_F);
    check("bp_occ2",     32'(occupancy), 32'd2);
    check("bp_in_ready", 32'(in_ready),  32'd0);
    check("bp_head",     out_data,       A_D);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("bp_pop_a", out_data, A_D);
    tick();
    check("bp_pop_b",     out_data,       B_D);
    check("bp_pop_b_flg", 32'(out_flags), 32'(B_F));
    check("bp_occ1",      32'(occupancy), 32'd1);
    tick();
    check("bp_drained", 32'(occupancy), 32'd0);

    // Halt and resume
    out_ready = 1'b0;
    push(A_D, A_F);
    in_valid = 1'b0; halt_cmd = 1'b1;
    #1;
    check("halt_cmd_ov", 32'(out_valid), 32'd0);
    check("halt_cmd_ir", 32'(in_ready),  32'd0);
    tick();
    halt_cmd = 1'b0; out_ready = 1'b1;
    #1;
    check("halted_flag",  32'(halted),    32'd1);
    check("halted_ov",    32'(out_valid), 32'd0);
    tick();
    check("halted_occ",   32'(occupancy), 32'd1);
    check("halted_data",  out_data,       A_D);
    out_ready = 1'b0; exec = 1'b1;
    #1;
    check("exec_unfreeze_ov", 32'(out_valid), 32'd1);
    tick();
    exec = 1'b0;
    #1;
    check("resume_halted", 32'(halted),    32'd0);
    check("resume_ov",     32'(out_valid), 32'd1);
    check("resume_data",   out_data,       A_D);
    out_ready = 1'b1;
    tick();
    check("resume_drained", 32'(occupancy), 32'd0);

    // Flush with two entries held, input offered but not captured
    out_ready = 1'b0;
    push(A_D, A_F);
    push(B_D, B_F);
    in_data = C_D; in_flags = C_F; flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready),  32'd0);
    check("flush_ov",       32'(out_valid), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_occ",   32'(occupancy), 32'd0);
    check("flush_data",  out_data,       32'd0);
    check("flush_flags", 32'(out_flags), 32'd0);
    tick();
    check("flush_no_capture", 32'(occupancy), 32'd0);

    // Flush ignored while halted; enable=0 also freezes
    push(A_D, A_F);
    in_valid = 1'b0; halt_cmd = 1'b1;
    tick();
    halt_cmd = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("halt_flush_occ",  32'(occupancy), 32'd1);
    check("halt_flush_data", out_data,       A_D);
    exec = 1'b1;
    tick();
    exec = 1'b0;
    #1;
    check("halt_flush_resume", 32'(halted), 32'd0);
    enable = 1'b0; in_valid = 1'b1; in_data = B_D; in_flags = B_F; out_ready = 1'b1;
    #1;
    check("disable_in_ready", 32'(in_ready),  32'd0);
    check("disable_ov",       32'(out_valid), 32'd0);
    tick();
    check("disable_occ",  32'(occupancy), 32'd1);
    check("disable_data", out_data,       A_D);
    enable = 1'b1; in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;

    // Reset in the middle of a transfer
    out_ready = 1'b0;
    push(A_D, A_F);
    push(B_D, B_F);
    check("pre_reset_occ", 32'(occupancy), 32'd2);
    reset = 1'b1; exec = 1'b1; out_ready = 1'b1; in_data = C_D;
    tick();
    reset = 1'b0; exec = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("midrst_occ",       32'(occupancy), 32'd0);
    check("midrst_halted",    32'(halted),    32'd0);
    check("midrst_ov",        32'(out_valid), 32'd0);
    check("midrst_data",      out_data,       32'd0);
    check("midrst_flags",     32'(out_flags), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_occ_noskid", 32'(occupancy0), 32'd0);

    // Single-entry variant: blocks when full, streams at full rate otherwise
    push(A_D, A_F);
    check("noskid_occ1",      32'(occupancy0), 32'd1);
    check("noskid_blocked",   32'(in_ready0),  32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = 32'h1000_2000 + 32'(i) * 32'h0001_0001;
      in_data = v; in_flags = 4'(i);
      #1;
      check("noskid_ready", 32'(in_ready0), 32'd1);
      tick();
      check("noskid_data",  out_data0,       v);
      check("noskid_flags", 32'(out_flags0), 32'(i));
      check("noskid_occ",   32'(occupancy0), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("noskid_drained", 32'(occupancy0), 32'd0);
    check("noskid_zero",    out_data0,       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
